// File: rtl/xyz_to_cct_estimator.sv
`timescale 1ns/1ps
// xyz_to_cct_estimator
// Estimates correlated colour temperature (Kelvin) from an XYZ white point.
// Chromaticity x = X/S and y = Y/S (S = X+Y+Z) feed McCamy's cubic
//   n   = (x - 0.3320) / (0.1858 - y)
//   cct = 449 n^3 + 3525 n^2 + 6823.3 n + 5520.33
// One bit-serial restoring divider and one multiplier are shared across
// all steps. A normal result takes 150 cycles; degenerate inputs return
// CCT_DEFAULT with cct_err set.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   xyz_in      X=[31:0], Y=[63:32], Z=[95:64], unsigned Q16.16
//   xyz_valid   one-cycle strobe, sampled only while idle (busy low)
//   cct_out     clamped CCT in Kelvin, holds until the next result
//   cct_valid   one-cycle pulse qualifying cct_out / cct_err
//   cct_err     degenerate input (S==0 or y==0.1858)
//   busy        high from the accept cycle through the cct_valid cycle
//   dbg_state   current FSM state, for observation only
//
// Handshake: xyz_in is captured on a rising edge where xyz_valid=1 and
// busy=0; strobes while busy is high are discarded without trace.
module xyz_to_cct_estimator #(
  parameter int unsigned CCT_MIN     = 1000,
  parameter int unsigned CCT_MAX     = 25000,
  parameter int unsigned CCT_DEFAULT = 6500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] xyz_in,
  input  logic        xyz_valid,
  output logic [15:0] cct_out,
  output logic        cct_valid,
  output logic        cct_err,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_SUM, S_DIV_X, S_DIV_Y, S_PREP_N, S_DIV_N, S_POLY, S_DONE
  } state_t;

  localparam logic [32:0] X_OFF = 33'h0_0000_54FE;  // 0.3320
  localparam logic [32:0] Y_OFF = 33'h0_0000_2F91;  // 0.1858
  localparam logic signed [47:0] C0 = 48'sh0000_01C1_0000;  // 449
  localparam logic signed [47:0] C1 = 48'sh0000_0DC5_0000;  // 3525
  localparam logic signed [47:0] C2 = 48'sh0000_1AA7_4CCD;  // 6823.3
  localparam logic signed [47:0] C3 = 48'sh0000_1590_547B;  // 5520.33
  localparam logic signed [47:0] ACC_MAX = 48'sh7FFF_FFFF_FFFF;
  localparam logic signed [47:0] ACC_MIN = 48'sh8000_0000_0000;
  localparam logic signed [32:0] MIN33 = 33'(CCT_MIN);
  localparam logic signed [32:0] MAX33 = 33'(CCT_MAX);

  state_t state, state_nx;

  logic [31:0] x_reg, y_reg, z_reg;   // captured tristimulus
  logic [47:0] dvd;                   // dividend in, quotient shifts in at LSB
  logic [31:0] rem, dvs;              // partial remainder, divisor
  logic [5:0]  cnt;
  logic [31:0] x_q, y_q;
  logic        n_neg, err_q;
  logic signed [31:0] n_q;
  logic signed [47:0] acc;

  // SUM
  logic [33:0] s_sum;
  logic [31:0] s_sat;
  assign s_sum = {2'b00, x_reg} + {2'b00, y_reg} + {2'b00, z_reg};
  assign s_sat = (s_sum[33:32] != 2'b00) ? 32'hFFFF_FFFF : s_sum[31:0];

  // One restoring-divide step per cycle
  logic [32:0] rem_sh;
  logic        div_ge;
  logic [31:0] rem_nx;
  logic [47:0] q_nx;
  logic [31:0] q_sat32;
  logic [30:0] n_mag;
  logic [31:0] n_nx;
  logic        div_last;
  assign rem_sh   = {rem, dvd[47]};
  assign div_ge   = rem_sh >= {1'b0, dvs};
  assign rem_nx   = div_ge ? 32'(rem_sh - {1'b0, dvs}) : rem_sh[31:0];
  assign q_nx     = {dvd[46:0], div_ge};
  assign q_sat32  = (q_nx[47:32] != 16'd0) ? 32'hFFFF_FFFF : q_nx[31:0];
  assign n_mag    = (q_nx[47:31] != 17'd0) ? 31'h7FFF_FFFF : q_nx[30:0];
  assign n_nx     = n_neg ? (32'd0 - {1'b0, n_mag}) : {1'b0, n_mag};
  assign div_last = (cnt == 6'd47);

  // PREP_N: signed 33-bit numerator/denominator and their magnitudes
  logic [32:0] num, den;
  logic [31:0] num_abs, den_abs;
  assign num     = {1'b0, x_q} - X_OFF;
  assign den     = Y_OFF - {1'b0, y_q};
  assign num_abs = num[32] ? 32'(33'd0 - num) : num[31:0];
  assign den_abs = den[32] ? 32'(33'd0 - den) : den[31:0];

  // POLY: Horner step, first step multiplies the leading coefficient
  logic signed [47:0] mul_b, addc, p48, acc_nx;
  logic signed [79:0] prod, prod_sh;
  logic signed [48:0] sum49;
  assign mul_b   = (cnt == 6'd0) ? C0 : acc;
  assign prod    = n_q * mul_b;
  assign prod_sh = prod >>> 16;
  assign p48     = (prod_sh[79:47] == {33{prod_sh[47]}}) ? prod_sh[47:0]
                 : (prod_sh[79] ? ACC_MIN : ACC_MAX);
  assign addc    = (cnt == 6'd0) ? C1 : ((cnt == 6'd1) ? C2 : C3);
  assign sum49   = {p48[47], p48} + {addc[47], addc};
  // Saturate the add as well so a railed product cannot wrap sign
  assign acc_nx  = (sum49[48] != sum49[47]) ? (sum49[48] ? ACC_MIN : ACC_MAX)
                 : sum49[47:0];

  // DONE: round to integer Kelvin and clamp
  logic signed [32:0] rnd;
  logic [15:0] cct_clamp;
  assign rnd = {acc[47], acc[47:16]} + {32'd0, acc[15]};
  always_comb begin
    cct_clamp = rnd[15:0];
    if (rnd < MIN33)      cct_clamp = 16'(CCT_MIN);
    else if (rnd > MAX33) cct_clamp = 16'(CCT_MAX);
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (xyz_valid && !cct_valid) state_nx = S_SUM;
      S_SUM:    state_nx = (s_sat == 32'd0) ? S_DONE : S_DIV_X;
      S_DIV_X:  if (div_last) state_nx = S_DIV_Y;
      S_DIV_Y:  if (div_last) state_nx = S_PREP_N;
      S_PREP_N: state_nx = (den == 33'd0) ? S_DONE : S_DIV_N;
      S_DIV_N:  if (div_last) state_nx = S_POLY;
      S_POLY:   if (cnt == 6'd2) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0; y_reg <= '0; z_reg <= '0;
      dvd <= '0; rem <= '0; dvs <= '0; cnt <= '0;
      x_q <= '0; y_q <= '0; n_neg <= 1'b0; n_q <= '0; acc <= '0;
      err_q <= 1'b0;
      cct_out <= '0; cct_valid <= 1'b0; cct_err <= 1'b0;
    end else begin
      cct_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xyz_valid && !cct_valid) begin
            x_reg <= xyz_in[31:0];
            y_reg <= xyz_in[63:32];
            z_reg <= xyz_in[95:64];
            err_q <= 1'b0;
          end
        end
        S_SUM: begin
          dvd <= {x_reg, 16'd0};
          rem <= '0;
          dvs <= s_sat;
          cnt <= '0;
          if (s_sat == 32'd0) err_q <= 1'b1;
        end
        S_DIV_X, S_DIV_Y, S_DIV_N: begin
          dvd <= q_nx;
          rem <= rem_nx;
          cnt <= cnt + 6'd1;
          if (div_last) begin
            cnt <= '0;
            if (state == S_DIV_X) begin
              x_q <= q_sat32;
              dvd <= {y_reg, 16'd0};   // same divisor S for y
              rem <= '0;
            end else if (state == S_DIV_Y) begin
              y_q <= q_sat32;
            end else begin
              n_q <= n_nx;
            end
          end
        end
        S_PREP_N: begin
          dvd   <= {num_abs, 16'd0};
          rem   <= '0;
          dvs   <= den_abs;
          cnt   <= '0;
          n_neg <= num[32] ^ den[32];
          if (den == 33'd0) err_q <= 1'b1;
        end
        S_POLY: begin
          acc <= acc_nx;
          cnt <= cnt + 6'd1;
        end
        S_DONE: begin
          cnt       <= '0;
          cct_valid <= 1'b1;
          cct_err   <= err_q;
          cct_out   <= err_q ? 16'(CCT_DEFAULT) : cct_clamp;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign busy      = (state != S_IDLE) || cct_valid;
  assign dbg_state = state;

endmodule

// File: tb/tb_xyz_to_cct_estimator.sv
`timescale 1ns/1ps
module tb_xyz_to_cct_estimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] xyz_in = '0;
  logic        xyz_valid = 1'b0;
  logic [15:0] cct_out;
  logic        cct_valid, cct_err, busy;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  xyz_to_cct_estimator dut (
    .clk(clk), .rst_n(rst_n), .xyz_in(xyz_in), .xyz_valid(xyz_valid),
    .cct_out(cct_out), .cct_valid(cct_valid), .cct_err(cct_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Drive one sample from idle, then wait (bounded) for its result.
  // lat counts rising edges after the accepting edge; -1 on timeout.
  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                     output int lat, output logic [15:0] c, output logic e,
                     output logic busy_ok);
    @(posedge clk);
    @(negedge clk);
    xyz_in = {z, y, x};
    xyz_valid = 1'b1;
    @(posedge clk); #1;
    xyz_valid = 1'b0;
    lat = -1; c = '0; e = 1'b0; busy_ok = busy;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (!busy) busy_ok = 1'b0;
      if (cct_valid) begin
        lat = k; c = cct_out; e = cct_err;
        break;
      end
    end
  endtask

  int          lat, lat2, pulses;
  logic [15:0] c, c1, c2;
  logic        e, bok;

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cct_out", 32'(cct_out), 0);
    chk("rst_cct_valid", 32'(cct_valid), 0);
    chk("rst_cct_err", 32'(cct_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // D65
    run(32'h0000F354, 32'h00010000, 32'h000116C9, lat, c, e, bok);
    chk("d65_lat", 32'(lat), 150);
    chk_rng("d65_cct", 32'(c), 6490, 6520);
    chk("d65_err", 32'(e), 0);
    chk("d65_busy", 32'(bok), 1);

    // D50-like
    run(32'h0000FFEE, 32'h00010000, 32'h0000C567, lat, c, e, bok);
    chk("d50_lat", 32'(lat), 150);
    chk_rng("d50_cct", 32'(c), 4476, 4506);

    // D65 at twice the luminance: same chromaticity
    run(32'h0001E6A8, 32'h00020000, 32'h00022D92, lat, c, e, bok);
    chk_rng("d65x2_cct", 32'(c), 6490, 6520);

    // polynomial far above the range
    run(32'h00010000, 32'h00000000, 32'h00000000, lat, c, e, bok);
    chk("clamp_hi_cct", 32'(c), 25000);
    chk("clamp_hi_err", 32'(e), 0);

    // n around -12.9, polynomial negative
    run(32'h00000000, 32'h00002000, 32'h0000A800, lat, c, e, bok);
    chk("clamp_lo_cct", 32'(c), 1000);

    // S = 2^32 saturates to 0xFFFFFFFF, x=y=0.5
    run(32'h80000000, 32'h80000000, 32'h00000000, lat, c, e, bok);
    chk_rng("ssat_cct", 32'(c), 2796, 2826);

    // S == 0
    run(32'h0, 32'h0, 32'h0, lat, c, e, bok);
    chk("zero_lat", 32'(lat), 2);
    chk("zero_cct", 32'(c), 6500);
    chk("zero_err", 32'(e), 1);

    // next good input clears the error
    run(32'h0000F354, 32'h00010000, 32'h000116C9, lat, c, e, bok);
    chk("clr_err", 32'(e), 0);
    chk_rng("clr_cct", 32'(c), 6490, 6520);

    // y exactly 0.1858 -> den == 0
    run(32'h00000000, 32'h00002F91, 32'h0000D06F, lat, c, e, bok);
    chk("den0_lat", 32'(lat), 99);
    chk("den0_cct", 32'(c), 6500);
    chk("den0_err", 32'(e), 1);

    // busy drop, then back-to-back accept on the cycle after cct_valid
    @(posedge clk);
    @(negedge clk);
    xyz_in = {32'h000116C9, 32'h00010000, 32'h0000F354};
    xyz_valid = 1'b1;
    @(posedge clk); #1;
    xyz_valid = 1'b0;
    pulses = 0; lat = -1; lat2 = -1; c1 = '0; c2 = '0;
    for (int k = 1; k <= 340; k++) begin
      @(posedge clk); #1;
      if (k == 20) begin
        xyz_in = {32'h0, 32'h0, 32'h00010000};
        xyz_valid = 1'b1;
      end
      if (k == 21) xyz_valid = 1'b0;
      if (lat > 0 && k == lat + 1) begin
        xyz_in = {32'h0000C567, 32'h00010000, 32'h0000FFEE};
        xyz_valid = 1'b1;
      end
      if (lat > 0 && k == lat + 2) xyz_valid = 1'b0;
      if (cct_valid) begin
        pulses++;
        if (pulses == 1) begin lat = k; c1 = cct_out; end
        else if (pulses == 2) begin lat2 = k; c2 = cct_out; end
      end
    end
    chk("drop_lat", 32'(lat), 150);
    chk_rng("drop_cct", 32'(c1), 6490, 6520);
    chk("b2b_pulses", 32'(pulses), 2);
    chk("b2b_lat", 32'(lat2 - lat), 152);
    chk_rng("b2b_cct", 32'(c2), 4476, 4506);

    // reset mid-operation
    @(posedge clk);
    @(negedge clk);
    xyz_in = {32'h000116C9, 32'h00010000, 32'h0000F354};
    xyz_valid = 1'b1;
    @(posedge clk); #1;
    xyz_valid = 1'b0;
    repeat (75) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cct_out", 32'(cct_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(cct_err), 0);
    chk("mid_rst_valid", 32'(cct_valid), 0);
    chk("mid_rst_state", 32'(dbg_state), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (cct_valid) pulses++;
    end
    chk("mid_rst_no_valid", 32'(pulses), 0);
    run(32'h0000F354, 32'h00010000, 32'h000116C9, lat, c, e, bok);
    chk("post_rst_lat", 32'(lat), 150);
    chk_rng("post_rst_cct", 32'(c), 6490, 6520);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
